// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative CORDIC vectoring core: signed (x,y) to magnitude and atan2 phase
module cordic_vectoring #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int ITERATIONS  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  x_in,
    input  logic [DATA_WIDTH-1:0]  y_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  mag_out,
    output logic [ANGLE_WIDTH-1:0] phase_out
);

    localparam int XW = DATA_WIDTH + 3;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int PW = XW + 17;
    localparam logic [16:0] INV_GAIN = 17'd39797;
    localparam logic [ANGLE_WIDTH-1:0] PI_CODE = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ITER  = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Elaboration-time arctan entry: pi maps to 2^(ANGLE_WIDTH-1), rounded to nearest.
    function automatic logic [ANGLE_WIDTH-1:0] atan_entry(input int i);
        real r;
        r = $atan(2.0 ** (-i)) / 3.14159265358979323846 * (2.0 ** (ANGLE_WIDTH - 1));
        return ANGLE_WIDTH'(longint'($floor(r + 0.5)));
    endfunction

    logic [ANGLE_WIDTH-1:0] atan_lut [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_lut
        assign atan_lut[g] = atan_entry(g);
    end

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d;
    logic signed [XW-1:0]    y_q, y_d;
    logic [ANGLE_WIDTH-1:0]  z_q, z_d;
    logic [CW-1:0]           iter_q, iter_d;
    logic                    zero_q, zero_d;
    logic [DATA_WIDTH-1:0]   mag_q, mag_d;
    logic [ANGLE_WIDTH-1:0]  phase_q, phase_d;
    logic                    valid_q, valid_d;

    logic signed [XW-1:0]    x_sh;
    logic signed [XW-1:0]    y_sh;
    logic [XW-2:0]           x_mag;
    logic [PW-1:0]           prod;
    logic [XW:0]             mag_full;
    logic [DATA_WIDTH-1:0]   mag_sat;

    assign x_sh = x_q >>> iter_q;
    assign y_sh = y_q >>> iter_q;

    // x is non-negative after the pre-rotation; clamp defensively before gain compensation.
    assign x_mag    = x_q[XW-1] ? '0 : x_q[XW-2:0];
    assign prod     = PW'(x_mag) * PW'(INV_GAIN) + PW'(32768);
    assign mag_full = (XW+1)'(prod >> 16);
    assign mag_sat  = (|mag_full[XW:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : mag_full[DATA_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        phase_d = phase_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = {{3{x_in[DATA_WIDTH-1]}}, x_in};
                    y_d     = {{3{y_in[DATA_WIDTH-1]}}, y_in};
                    zero_d  = (x_in == '0) && (y_in == '0);
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                // Fold the left half-plane onto the right; +pi and -pi share one code.
                if (x_q[XW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = PI_CODE;
                end else begin
                    z_d = '0;
                end
                iter_d  = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_lut[iter_q];
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_lut[iter_q];
                end
                iter_d = iter_q + CW'(1);
                if (iter_q == CW'(ITERATIONS - 1)) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                // The rotation sequence for (0,0) still accumulates z, so force an exact zero phase.
                mag_d   = mag_sat;
                phase_d = zero_q ? '0 : z_q;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = valid_q;
    assign mag_out   = mag_q;
    assign phase_out = phase_q;

endmodule
